// File: rtl/poker_hand_ctrl.sv
// rtl/poker_hand_ctrl.sv - video-poker hand sequencer: shuffle, deal and draw through the deck handshake.
// Optional per-phase handshake timeout with ERR state and hand_err port: POKER_HAND_TIMEOUT_EN.
module poker_hand_ctrl #(
  parameter int HAND_SIZE      = 5,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   new_hand,
  input  logic                   draw,
  input  logic [HAND_SIZE-1:0]   hold,
  output logic                   deck_deal,
  output logic                   deck_shuffle,
  input  logic                   deck_dealt,
  input  logic [3:0]             deck_rank,
  input  logic [1:0]             deck_suit,
  output logic [4*HAND_SIZE-1:0] hand_rank,
  output logic [2*HAND_SIZE-1:0] hand_suit,
  output logic                   hand_valid,
  output logic                   hand_done,
  output logic                   drawn,
  output logic                   busy
`ifdef POKER_HAND_TIMEOUT_EN
  ,
  output logic                   hand_err
`endif
);

  localparam int IW = $clog2(HAND_SIZE + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHUF,
    S_SEL,
    S_REQ,
    S_REL,
    S_READY
`ifdef POKER_HAND_TIMEOUT_EN
    ,
    S_ERR
`endif
  } state_e;

  state_e                 state_q, state_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [HAND_SIZE-1:0]   mask_q, mask_d;
  logic [4*HAND_SIZE-1:0] rank_q, rank_d;
  logic [2*HAND_SIZE-1:0] suit_q, suit_d;
  logic                   drawn_q, drawn_d;
  logic                   done_q, done_d;
  logic                   sel_hit;
  logic                   idx_end;

`ifdef POKER_HAND_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          tmo;
  assign tmo = (cnt_q == CW'(TIMEOUT_CYCLES - 1));
`endif

  assign idx_end = (idx_q >= IW'(HAND_SIZE));

  always_comb begin
    sel_hit = 1'b0;
    for (int i = 0; i < HAND_SIZE; i++) begin
      if (idx_q == IW'(i)) sel_hit = mask_q[i];
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    mask_d  = mask_q;
    rank_d  = rank_q;
    suit_d  = suit_q;
    drawn_d = drawn_q;
    done_d  = 1'b0;
`ifdef POKER_HAND_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (new_hand) state_d = S_SHUF;
      end
      S_SHUF: begin
        drawn_d = 1'b0;
        mask_d  = '1;
        idx_d   = '0;
        state_d = S_SEL;
      end
      S_SEL: begin
        if (idx_end) begin
          state_d = S_READY;
          done_d  = 1'b1;
        end else if (!sel_hit) begin
          idx_d = idx_q + IW'(1);
        end else if (!deck_dealt) begin
          state_d = S_REQ;
`ifdef POKER_HAND_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      S_REQ: begin
        // Slot data is only taken while the deck acknowledges; rank/suit float otherwise.
        if (deck_dealt) begin
          for (int i = 0; i < HAND_SIZE; i++) begin
            if (idx_q == IW'(i)) begin
              rank_d[4*i +: 4] = deck_rank;
              suit_d[2*i +: 2] = deck_suit;
            end
          end
          state_d = S_REL;
`ifdef POKER_HAND_TIMEOUT_EN
          cnt_d   = '0;
        end else if (tmo) begin
          state_d = S_ERR;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
`endif
        end
      end
      S_REL: begin
        if (!deck_dealt) begin
          idx_d   = idx_q + IW'(1);
          state_d = S_SEL;
`ifdef POKER_HAND_TIMEOUT_EN
        end else if (tmo) begin
          state_d = S_ERR;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
`endif
        end
      end
      S_READY: begin
        if (new_hand) begin
          state_d = S_SHUF;
        end else if (draw && !drawn_q) begin
          mask_d  = ~hold;
          idx_d   = '0;
          drawn_d = 1'b1;
          state_d = S_SEL;
        end
      end
`ifdef POKER_HAND_TIMEOUT_EN
      S_ERR: begin
        if (new_hand) begin
          state_d = S_SHUF;
          err_d   = 1'b0;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      mask_q  <= '0;
      rank_q  <= '0;
      suit_q  <= '0;
      drawn_q <= 1'b0;
      done_q  <= 1'b0;
`ifdef POKER_HAND_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      mask_q  <= mask_d;
      rank_q  <= rank_d;
      suit_q  <= suit_d;
      drawn_q <= drawn_d;
      done_q  <= done_d;
`ifdef POKER_HAND_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  assign deck_deal    = (state_q == S_REQ);
  assign deck_shuffle = (state_q == S_SHUF);
  assign hand_rank    = rank_q;
  assign hand_suit    = suit_q;
  assign hand_valid   = (state_q == S_READY);
  assign hand_done    = done_q;
  assign drawn        = drawn_q;
  assign busy         = (state_q == S_SHUF) || (state_q == S_SEL) ||
                        (state_q == S_REQ)  || (state_q == S_REL);
`ifdef POKER_HAND_TIMEOUT_EN
  assign hand_err     = err_q;
`endif

endmodule

// File: tb/tb_poker_hand_ctrl.sv
// tb/tb_poker_hand_ctrl.sv - scoreboard bench for poker_hand_ctrl with a queue-fed deck model.
module tb_poker_hand_ctrl;
  localparam int N = 5;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           new_hand = 1'b0;
  logic           draw = 1'b0;
  logic [N-1:0]   hold = '0;
  logic           deck_deal, deck_shuffle;
  logic           deck_dealt;
  logic [3:0]     deck_rank;
  logic [1:0]     deck_suit;
  logic [4*N-1:0] hand_rank;
  logic [2*N-1:0] hand_suit;
  logic           hand_valid, hand_done, drawn, busy;
`ifdef POKER_HAND_TIMEOUT_EN
  logic           hand_err;
`endif

  logic       deck_auto = 1'b1;
  logic       auto_dealt = 1'b0, man_dealt = 1'b0;
  logic [3:0] auto_rank = 'x, man_rank = 'x;
  logic [1:0] auto_suit = 'x, man_suit = 'x;
  assign deck_dealt = deck_auto ? auto_dealt : man_dealt;
  assign deck_rank  = deck_auto ? auto_rank  : man_rank;
  assign deck_suit  = deck_auto ? auto_suit  : man_suit;

  always #5 clk = ~clk;

  poker_hand_ctrl #(.HAND_SIZE(N), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .new_hand(new_hand), .draw(draw), .hold(hold),
    .deck_deal(deck_deal), .deck_shuffle(deck_shuffle), .deck_dealt(deck_dealt),
    .deck_rank(deck_rank), .deck_suit(deck_suit), .hand_rank(hand_rank),
    .hand_suit(hand_suit), .hand_valid(hand_valid), .hand_done(hand_done),
    .drawn(drawn), .busy(busy)
`ifdef POKER_HAND_TIMEOUT_EN
    , .hand_err(hand_err)
`endif
  );

  typedef struct packed { logic [3:0] r; logic [1:0] s; } card_t;
  typedef struct { logic [4*N-1:0] r; logic [2*N-1:0] s; logic d; } exp_t;

  card_t feed[$];
  exp_t  exp_q[$];
  card_t m_slot[N];
  card_t cbuf[N];
  bit    m_drawn = 0;
  int    n_chk = 0, n_pass = 0;
  int    shuf_cnt = 0, deal_cyc = 0, ack_cnt = 0, done_cnt = 0, x_seen = 0;
  int    ack_dly = 2;
  bit    rand_dly = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic rand_cards();
    for (int i = 0; i < N; i++) begin
      cbuf[i].r = 4'($urandom_range(1, 13));
      cbuf[i].s = 2'($urandom);
    end
  endtask

  task automatic push_exp();
    exp_t e;
    for (int i = 0; i < N; i++) begin
      e.r[4*i +: 4] = m_slot[i].r;
      e.s[2*i +: 2] = m_slot[i].s;
    end
    e.d = m_drawn;
    exp_q.push_back(e);
  endtask

  task automatic wait_hand(input int start);
    int n = 0;
    while (done_cnt == start && n < 400) begin
      tick();
      n++;
    end
    chk("hand_done_seen", 32'(done_cnt != start), 1);
  endtask

  // Monitor: counts deck traffic and scores every completed hand against the model.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (deck_shuffle) shuf_cnt++;
    if (deck_deal) deal_cyc++;
    if ($isunknown({hand_rank, hand_suit})) x_seen++;
    if (!rst && hand_done) begin
      done_cnt++;
      if (exp_q.size() == 0) chk("unexpected_hand_done", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("hand_rank", 32'(hand_rank), 32'(e.r));
        chk("hand_suit", 32'(hand_suit), 32'(e.s));
        chk("drawn", 32'(drawn), 32'(e.d));
        chk("hand_valid", 32'(hand_valid), 1);
      end
    end
  end

  // Deck: acknowledges a deal request with the next queued card, releases after deal drops.
  initial begin : deck_model
    card_t c;
    int d, rd, n;
    forever begin
      @(negedge clk);
      if (deck_auto && deck_deal && !auto_dealt) begin
        d  = rand_dly ? int'($urandom_range(1, 3)) : ack_dly;
        rd = rand_dly ? int'($urandom_range(0, 2)) : 0;
        repeat (d - 1) @(negedge clk);
        if (feed.size() == 0) begin
          chk("deck_feed_empty", 1, 0);
          c = '0;
        end else c = feed.pop_front();
        auto_rank = c.r; auto_suit = c.s; auto_dealt = 1'b1;
        ack_cnt++;
        n = 0;
        while (deck_deal && n < 200) begin
          @(negedge clk);
          n++;
        end
        repeat (rd) @(negedge clk);
        auto_dealt = 1'b0; auto_rank = 'x; auto_suit = 'x;
      end
    end
  end

  task automatic issue_new();
    int s0 = shuf_cnt, d0 = done_cnt;
    for (int i = 0; i < N; i++) begin
      m_slot[i] = cbuf[i];
      feed.push_back(cbuf[i]);
    end
    m_drawn = 0;
    push_exp();
    new_hand = 1'b1;
    tick();
    new_hand = 1'b0;
    wait_hand(d0);
    tick();
    chk("shuffle_pulses", 32'(shuf_cnt - s0), 1);
    chk("busy_after_deal", 32'(busy), 0);
  endtask

  task automatic issue_draw(input logic [N-1:0] h);
    int  s0 = shuf_cnt, d0 = done_cnt, a0 = ack_cnt, c0 = deal_cyc, want = 0;
    bit  take = !m_drawn;
    if (take) begin
      for (int i = 0; i < N; i++)
        if (!h[i]) begin
          m_slot[i] = cbuf[i];
          feed.push_back(cbuf[i]);
          want++;
        end
      m_drawn = 1;
      push_exp();
    end
    draw = 1'b1; hold = h;
    tick();
    draw = 1'b0; hold = N'($urandom);
    if (take) wait_hand(d0);
    else begin
      tick(12);
      chk("ignored_draw_done", 32'(done_cnt - d0), 0);
    end
    tick();
    chk("draw_no_shuffle", 32'(shuf_cnt - s0), 0);
    chk("draw_acks", 32'(ack_cnt - a0), 32'(want));
    if (h == '1) chk("all_hold_no_deal", 32'(deal_cyc - c0), 0);
    chk("drawn_after_draw", 32'(drawn), 1);
  endtask

  initial begin : stim
    int d0, c0, n;
    tick(3);
    chk("rst_deck_deal", 32'(deck_deal), 0);
    chk("rst_deck_shuffle", 32'(deck_shuffle), 0);
    chk("rst_hand_rank", 32'(hand_rank), 0);
    chk("rst_hand_suit", 32'(hand_suit), 0);
    chk("rst_flags", 32'({hand_valid, hand_done, drawn, busy}), 0);
    rst = 1'b0;
    tick();

    // Basic deal with fixed cards.
    cbuf[0] = '{4'd1, 2'd2}; cbuf[1] = '{4'd5, 2'd2}; cbuf[2] = '{4'd9, 2'd2};
    cbuf[3] = '{4'd12, 2'd2}; cbuf[4] = '{4'd13, 2'd2};
    issue_new();
    chk("basic_rank", 32'(hand_rank), 32'h000DC951);
    chk("basic_suit", 32'(hand_suit), 32'h2AA);

    // Partial draw keeping slots 0, 2, 4.
    rand_cards();
    cbuf[1] = '{4'd3, 2'd1}; cbuf[3] = '{4'd7, 2'd1};
    issue_draw(5'b10101);
    chk("pdraw_rank", 32'(hand_rank), 32'h000D7931);
    issue_draw(5'b00000);

    // Hold everything, then a second draw that must be ignored.
    rand_cards(); issue_new();
    issue_draw(5'b11111);
    rand_cards(); issue_draw(5'b01010);

    // new_hand and draw together in READY: the shuffle wins.
    rand_cards(); issue_new();
    rand_cards();
    for (int i = 0; i < N; i++) begin
      m_slot[i] = cbuf[i];
      feed.push_back(cbuf[i]);
    end
    m_drawn = 0;
    push_exp();
    d0 = done_cnt;
    new_hand = 1'b1; draw = 1'b1; hold = '0;
    tick();
    new_hand = 1'b0; draw = 1'b0;
    chk("new_hand_priority_shuf", 32'(deck_shuffle), 1);
    wait_hand(d0);

    // Reset while the deck is acknowledging.
    deck_auto = 1'b0; man_dealt = 1'b0;
    new_hand = 1'b1; tick(); new_hand = 1'b0;
    n = 0;
    while (!deck_deal && n < 50) begin tick(); n++; end
    chk("reached_req", 32'(deck_deal), 1);
    man_dealt = 1'b1; man_rank = 4'd9; man_suit = 2'd3;
    rst = 1'b1;
    tick();
    chk("deal_drop_on_rst", 32'(deck_deal), 0);
    chk("partial_discarded", 32'(hand_rank), 0);
    rst = 1'b0;
    rand_cards();
    for (int i = 0; i < N; i++) begin
      m_slot[i] = cbuf[i];
      feed.push_back(cbuf[i]);
    end
    m_drawn = 0;
    push_exp();
    d0 = done_cnt; c0 = deal_cyc;
    new_hand = 1'b1; tick(); new_hand = 1'b0;
    tick(2);
    chk("no_deal_while_dealt", 32'(deal_cyc - c0), 0);
    man_dealt = 1'b0; man_rank = 'x; man_suit = 'x;
    deck_auto = 1'b1;
    wait_hand(d0);

    // Randomized hands and draws with variable deck latency.
    rand_dly = 1;
    for (int k = 0; k < 8; k++) begin
      rand_cards(); issue_new();
      rand_cards(); issue_draw(N'($urandom));
      if ($urandom_range(0, 1) == 1) begin
        rand_cards(); issue_draw(N'($urandom));
      end
    end

`ifdef POKER_HAND_TIMEOUT_EN
    // Deck never answers: ERR after eight REQ cycles, new_hand recovers.
    deck_auto = 1'b0; man_dealt = 1'b0;
    new_hand = 1'b1; tick(); new_hand = 1'b0;
    n = 0;
    while (!deck_deal && n < 50) begin tick(); n++; end
    tick(8);
    chk("tmo_err", 32'(hand_err), 1);
    chk("tmo_deal_low", 32'(deck_deal), 0);
    chk("tmo_valid_low", 32'(hand_valid), 0);
    rand_cards();
    for (int i = 0; i < N; i++) begin
      m_slot[i] = cbuf[i];
      feed.push_back(cbuf[i]);
    end
    m_drawn = 0;
    push_exp();
    d0 = done_cnt;
    deck_auto = 1'b1;
    new_hand = 1'b1; tick(); new_hand = 1'b0;
    chk("tmo_err_cleared", 32'(hand_err), 0);
    chk("tmo_shuf", 32'(deck_shuffle), 1);
    wait_hand(d0);
`endif

    tick(5);
    chk("exp_queue_empty", 32'(exp_q.size()), 0);
    chk("deck_feed_drained", 32'(feed.size()), 0);
    chk("no_x_on_hand", 32'(x_seen), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_chk);
    $fatal(1);
  end

endmodule
